// File: rtl/vga_pkg.sv
// VGA 640x480 timing constants and the arbiter state type shared by the
// vblank update arbiter and its round-robin sub-block.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = 525;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        WINDOW = 2'd1,
        COMMIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches eligible (req & mask) lines
// starting at ptr_i and wrapping; returns the one-hot winner and a valid flag.
module rr_arbiter
    import vga_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             valid_o
);

    logic [N-1:0] eligible;

    assign eligible = req_i & mask_i;

    // First eligible line at or after the pointer, wrapping modulo N.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && eligible[(int'(ptr_i) + i) % N]) begin
                gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblank_update_arbiter.sv
// Vertical-blank update arbiter: shares the object register-file write port
// between N_REQ requesters, only lets writes land between OPEN_LINE and
// CLOSE_LINE, and pulses frame_commit as the window closes.
// Optional feature macro: VBLANK_ARB_STATS_EN (missed-request counter).
//
// Handshake: a requester raises req with addr/data and holds it; a grant
// pulse on gnt (with wr_en/wr_addr/wr_data) one cycle after the decision
// completes the transfer and the requester drops req the following cycle.
// The just-granted line is masked for one cycle so it is never regranted
// back to back.
module vblank_update_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int OPEN_LINE  = 480,
    parameter int CLOSE_LINE = 520,
    parameter int MAX_GRANTS = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                hcount,
    input  logic [9:0]                vcount,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      window_open,
    output logic                      frame_commit,
    output logic [7:0]                missed_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BUD_W = $clog2(MAX_GRANTS + 1);
    localparam logic [9:0]       OPEN_V   = 10'(OPEN_LINE);
    localparam logic [9:0]       CLOSE_V  = 10'(CLOSE_LINE);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [BUD_W-1:0] BUD_FULL = BUD_W'(MAX_GRANTS);

    // Reject window placements that would straddle the frame wrap.
    generate
        if (!(CLOSE_LINE > OPEN_LINE && CLOSE_LINE < V_TOTAL)) begin : g_bad_cfg
            $error("vblank_update_arbiter: need OPEN_LINE < CLOSE_LINE < V_TOTAL");
        end
    endgenerate

    arb_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [BUD_W-1:0]    budget_q, budget_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                win_open_q, win_open_d;
    logic                commit_q, commit_d;

    logic                open_hit, close_hit, grant_ok;
    logic [N_REQ-1:0]    arb_req, win_oh;
    logic                win_valid;
    logic [PTR_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    assign open_hit  = (vcount == OPEN_V)  && (hcount == 10'd0);
    assign close_hit = (vcount == CLOSE_V) && (hcount == 10'd0);
    // No decision in the closing cycle, so the last write always lands
    // at least one cycle before frame_commit.
    assign grant_ok  = (state_q == WINDOW) && !close_hit && (budget_q != '0);
    assign arb_req   = req & {N_REQ{grant_ok}};

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req_i   (arb_req),
        .mask_i  (~gnt_q),
        .ptr_i   (ptr_q),
        .gnt_o   (win_oh),
        .valid_o (win_valid)
    );

    // Decode the one-hot winner into an index and pick its address/data.
    always_comb begin
        win_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = PTR_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state, budget, pointer and registered-output computation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        budget_d  = budget_q;
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ACTIVE: begin
                if (open_hit) begin
                    state_d  = WINDOW;
                    budget_d = BUD_FULL;
                end
            end
            WINDOW: begin
                if (close_hit) begin
                    state_d = COMMIT;
                end else if (win_valid) begin
                    gnt_d     = win_oh;
                    wr_en_d   = 1'b1;
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                    budget_d  = budget_q - BUD_W'(1);
                    ptr_d     = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
                end
            end
            COMMIT: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
        win_open_d = (state_d == WINDOW);
        commit_d   = (state_d == COMMIT);
    end

    // State and output registers; reset aborts any open window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACTIVE;
            ptr_q      <= '0;
            budget_q   <= '0;
            gnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            win_open_q <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            budget_q   <= budget_d;
            gnt_q      <= gnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            win_open_q <= win_open_d;
            commit_q   <= commit_d;
        end
    end

    assign gnt          = gnt_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign window_open  = win_open_q;
    assign frame_commit = commit_q;

`ifdef VBLANK_ARB_STATS_EN
    logic [7:0] missed_q, missed_d;
    int         pop;

    // Count requesters still pending in the closing cycle, saturating.
    always_comb begin
        pop      = 0;
        missed_d = missed_q;
        if ((state_q == WINDOW) && close_hit) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) pop = pop + 1;
            end
            missed_d = (pop > 255) ? 8'd255 : 8'(pop);
        end
    end

    // Held from one commit to the next.
    always_ff @(posedge clk) begin
        if (reset) missed_q <= 8'd0;
        else       missed_q <= missed_d;
    end

    assign missed_cnt = missed_q;
`else
    assign missed_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Bench for vblank_update_arbiter: drives hcount/vcount directly (jumping to
// the lines of interest), pushes expected writes/commits with their cycle
// stamps into queues, and a negedge monitor pops and compares them.
module tb_vblank_update_arbiter;

    localparam int MAXG = 5;
`ifdef VBLANK_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hcount = 10'd0;
    logic [9:0]  vcount = 10'd0;
    logic [3:0]  req = 4'b0;
    logic [15:0] req_addr = 16'h0;
    logic [63:0] req_data = 64'h0;
    logic [3:0]  gnt;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        window_open;
    logic        frame_commit;
    logic [7:0]  missed_cnt;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    int unsigned c;

    logic [55:0] exp_q[$];   // {cycle, gnt, addr, data}
    logic [39:0] com_q[$];   // {cycle, missed_cnt}
    logic [55:0] mon_e;
    logic [39:0] mon_c;

    vblank_update_arbiter #(
        .N_REQ(4), .ADDR_W(4), .DATA_W(16),
        .OPEN_LINE(480), .CLOSE_LINE(520), .MAX_GRANTS(MAXG)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .window_open(window_open), .frame_commit(frame_commit),
        .missed_cnt(missed_cnt)
    );

    // Clock and cycle stamp.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs change #1 after the edge, counters advance like
    // the timing generator.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hcount == 10'd799) begin
            hcount = 10'd0;
            vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 10'd1;
        end
    endtask

    task automatic set_pos(input int v, input int h);
        vcount = 10'(v);
        hcount = 10'(h);
    endtask

    task automatic set_slot(input int i, input logic [3:0] a, input logic [15:0] d);
        req_addr[i*4 +: 4]  = a;
        req_data[i*16 +: 16] = d;
    endtask

    task automatic push_w(input int unsigned cy, input logic [3:0] g,
                          input logic [3:0] a, input logic [15:0] d);
        exp_q.push_back({cy, g, a, d});
    endtask

    task automatic push_c(input int unsigned cy, input logic [7:0] m);
        com_q.push_back({cy, m});
    endtask

    // Scoreboard monitor: every write or commit the DUT shows must match
    // the head of its queue, including the cycle it appears in.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en === 1'b1 || gnt !== 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: cyc %0d gnt %b addr %0h data %0h, none expected",
                             cyc, gnt, wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write", {7'b0, cyc, gnt, wr_en, wr_addr, wr_data},
                        {7'b0, mon_e[55:24], mon_e[23:20], 1'b1, mon_e[19:0]});
                end
            end
            if (frame_commit === 1'b1) begin
                if (com_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_commit: cyc %0d missed %0d, none expected", cyc, missed_cnt);
                end else begin
                    mon_c = com_q.pop_front();
                    chk("commit", {24'b0, cyc, missed_cnt}, {24'b0, mon_c});
                end
            end
        end
    end

    initial begin
        set_slot(0, 4'h1, 16'hD000);
        set_slot(1, 4'h4, 16'hD111);
        set_slot(2, 4'h7, 16'hD222);
        set_slot(3, 4'hA, 16'hD333);

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_wr_en", 64'(wr_en), 64'h0);
        chk("rst_wr_addr", 64'(wr_addr), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_window_open", 64'(window_open), 64'h0);
        chk("rst_frame_commit", 64'(frame_commit), 64'h0);
        chk("rst_missed_cnt", 64'(missed_cnt), 64'h0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Request during active video stays pending; window opens at (480,0)
        set_pos(100, 0);
        req = 4'b0001;
        repeat (10) tick();
        chk("active_no_gnt", 64'(gnt), 64'h0);
        c = cyc;
        set_pos(480, 0);
        push_w(c + 2, 4'b0001, 4'h1, 16'hD000);
        tick();
        chk("open_window_open", 64'(window_open), 64'h1);
        chk("open_no_commit", 64'(frame_commit), 64'h0);
        tick();
        tick();
        req = 4'b0000;
        repeat (4) tick();
        c = cyc;
        set_pos(520, 0);
        push_c(c + 1, 8'd0);
        tick();
        chk("close_window_open", 64'(window_open), 64'h0);
        tick();
        chk("commit_one_cycle", 64'(frame_commit), 64'h0);
        repeat (3) tick();

        // All four held: rotation from pointer 1, budget stops at 5 grants
        c = cyc;
        set_pos(480, 0);
        req = 4'b1111;
        push_w(c + 2, 4'b0010, 4'h4, 16'hD111);
        push_w(c + 3, 4'b0100, 4'h7, 16'hD222);
        push_w(c + 4, 4'b1000, 4'hA, 16'hD333);
        push_w(c + 5, 4'b0001, 4'h1, 16'hD000);
        push_w(c + 6, 4'b0010, 4'h4, 16'hD111);
        repeat (12) tick();
        chk("budget_open_still", 64'(window_open), 64'h1);
        req = 4'b0111;
        tick();
        c = cyc;
        set_pos(520, 0);
        push_c(c + 1, STATS ? 8'd3 : 8'd0);
        repeat (3) tick();
        chk("missed_hold", 64'(missed_cnt), STATS ? 64'd3 : 64'd0);
        req = 4'b0000;
        repeat (3) tick();

        // Single requester holding req: regranted every other cycle,
        // data sampled in the decision cycle
        c = cyc;
        set_pos(480, 0);
        req = 4'b0100;
        push_w(c + 2,  4'b0100, 4'h7, 16'h1002);
        push_w(c + 4,  4'b0100, 4'h7, 16'h1004);
        push_w(c + 6,  4'b0100, 4'h7, 16'h1006);
        push_w(c + 8,  4'b0100, 4'h7, 16'h1008);
        push_w(c + 10, 4'b0100, 4'h7, 16'h100A);
        for (int k = 1; k <= 12; k++) begin
            req_data[2*16 +: 16] = 16'h1000 + 16'(k);
            tick();
        end
        set_slot(2, 4'h7, 16'hD222);
        c = cyc;
        set_pos(520, 0);
        push_c(c + 1, STATS ? 8'd1 : 8'd0);
        repeat (2) tick();
        req = 4'b0000;
        repeat (3) tick();

        // Close while grants are still flowing: no grant in the closing cycle
        c = cyc;
        set_pos(480, 0);
        req = 4'b0011;
        push_w(c + 2, 4'b0001, 4'h1, 16'hD000);
        push_w(c + 3, 4'b0010, 4'h4, 16'hD111);
        push_w(c + 4, 4'b0001, 4'h1, 16'hD000);
        repeat (4) tick();
        set_pos(520, 0);
        push_c(c + 5, STATS ? 8'd2 : 8'd0);
        repeat (4) tick();
        req = 4'b0000;
        repeat (2) tick();

        // Reset mid-window aborts it; no commit at the following close
        c = cyc;
        set_pos(480, 0);
        req = 4'b1100;
        push_w(c + 2, 4'b0100, 4'h7, 16'hD222);
        tick();
        tick();
        set_pos(500, 0);
        reset = 1'b1;
        tick();
        chk("midrst_gnt", 64'(gnt), 64'h0);
        chk("midrst_wr_en", 64'(wr_en), 64'h0);
        chk("midrst_window_open", 64'(window_open), 64'h0);
        chk("midrst_missed_cnt", 64'(missed_cnt), 64'h0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        set_pos(520, 0);
        repeat (6) tick();
        chk("midrst_no_commit", 64'(frame_commit), 64'h0);
        chk("midrst_still_closed", 64'(window_open), 64'h0);

        // Next window after reset: pointer restarts at 0, budget reloaded
        c = cyc;
        set_pos(480, 0);
        push_w(c + 2, 4'b0100, 4'h7, 16'hD222);
        push_w(c + 3, 4'b1000, 4'hA, 16'hD333);
        push_w(c + 4, 4'b0100, 4'h7, 16'hD222);
        push_w(c + 5, 4'b1000, 4'hA, 16'hD333);
        push_w(c + 6, 4'b0100, 4'h7, 16'hD222);
        repeat (10) tick();
        c = cyc;
        set_pos(520, 0);
        push_c(c + 1, STATS ? 8'd2 : 8'd0);
        repeat (3) tick();
        req = 4'b0000;
        repeat (4) tick();

        chk("writes_outstanding", 64'(exp_q.size()), 64'h0);
        chk("commits_outstanding", 64'(com_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
